// File: rtl/neural50_pkg.sv
// Shared constants and state encoding for the 50-lane neuron sequencer.
package neural50_pkg;

    localparam int unsigned LANES      = 50;
    localparam int unsigned DW         = 8;
    localparam int unsigned MAX_CHUNKS = 16;
    localparam int unsigned CAW        = 5;
    localparam int unsigned NAW        = 8;
    localparam int unsigned VW         = LANES * DW;

    // 0x10 * bias, sliced [11:4], reproduces the bias byte unchanged.
    localparam logic [DW-1:0] BIAS_ONE = 8'h10;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/neural50_step_gen.sv
// Step/neuron counters and read-address generation for the sequencer.
module neural50_step_gen
    import neural50_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [CAW-1:0]     num_chunks,
    input  logic [NAW-1:0]     num_neurons,
    input  logic               step,
    input  logic               next_neuron,
    output logic [CAW-1:0]     step_idx,
    output logic [NAW-1:0]     neuron_idx,
    output logic [NAW+CAW-1:0] w_addr,
    output logic               first_step,
    output logic               last_step,
    output logic               last_neuron
);

    localparam logic [CAW-1:0] BIAS_IDX = CAW'(MAX_CHUNKS);

    logic [CAW-1:0] nc_q;
    logic [NAW-1:0] nn_q;
    logic [CAW-1:0] s_q;
    logic [NAW-1:0] k_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            nc_q <= '0;
            nn_q <= '0;
            s_q  <= '0;
            k_q  <= '0;
        end else if (load) begin
            nc_q <= num_chunks;
            nn_q <= num_neurons;
            s_q  <= '0;
            k_q  <= '0;
        end else if (next_neuron) begin
            k_q <= k_q + NAW'(1);
            s_q <= '0;
        end else if (step) begin
            s_q <= s_q + CAW'(1);
        end
    end

    always_comb begin
        step_idx    = s_q;
        neuron_idx  = k_q;
        first_step  = (s_q == '0);
        last_step   = (s_q == nc_q);
        last_neuron = ({1'b0, k_q} + 9'd1) == {1'b0, nn_q};
        // The bias word lives at a fixed chunk slot past the data chunks.
        w_addr      = {k_q, (last_step ? BIAS_IDX : s_q)};
    end

endmodule

// File: rtl/neural50_sequencer.sv
// Layer sequencer: streams input/weight chunks and a bias step into the MAC
// neuron for each neuron of a layer, then writes each neuron result out.
module neural50_sequencer
    import neural50_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CAW-1:0]     num_chunks,
    input  logic [NAW-1:0]     num_neurons,
    output logic               busy,
    output logic               done,
    output logic               in_rd,
    output logic [CAW-1:0]     in_addr,
    input  logic [VW-1:0]      in_chunk,
    output logic               w_rd,
    output logic [NAW+CAW-1:0] w_addr,
    input  logic [VW-1:0]      w_chunk,
    output logic [VW-1:0]      n_input,
    output logic [VW-1:0]      n_weight,
    output logic               n_zero,
    output logic               n_isbias,
    output logic [DW-1:0]      n_last,
    input  logic [DW-1:0]      n_out,
    output logic               res_we,
    output logic [NAW-1:0]     res_addr,
    output logic [DW-1:0]      res_data
);

    state_e state_q, state_d;
    logic   drain_q;
    logic   load, step, next_neuron, issue;

    logic [CAW-1:0]     step_idx;
    logic [NAW-1:0]     neuron_idx;
    logic [NAW+CAW-1:0] gen_w_addr;
    logic               first_step, last_step, last_neuron;

    // Read data returns one cycle after the strobe; these flags follow it.
    logic feed_q, feed_bias_q, feed_first_q;

    neural50_step_gen u_step_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .num_chunks  (num_chunks),
        .num_neurons (num_neurons),
        .step        (step),
        .next_neuron (next_neuron),
        .step_idx    (step_idx),
        .neuron_idx  (neuron_idx),
        .w_addr      (gen_w_addr),
        .first_step  (first_step),
        .last_step   (last_step),
        .last_neuron (last_neuron)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == StDrain) && !drain_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        step        = 1'b0;
        next_neuron = 1'b0;
        issue       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        in_rd       = 1'b0;
        w_rd        = 1'b0;
        res_we      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = (num_neurons == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                busy  = 1'b1;
                issue = 1'b1;
                step  = 1'b1;
                w_rd  = 1'b1;
                in_rd = !last_step;
                if (last_step) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                busy = 1'b1;
                if (drain_q) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                busy        = 1'b1;
                res_we      = 1'b1;
                next_neuron = 1'b1;
                state_d     = last_neuron ? StDone : StIssue;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_addr  = in_rd ? step_idx : '0;
        w_addr   = w_rd ? gen_w_addr : '0;
        res_addr = res_we ? neuron_idx : '0;
        res_data = res_we ? n_out : '0;
        n_last   = n_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            feed_q       <= 1'b0;
            feed_bias_q  <= 1'b0;
            feed_first_q <= 1'b0;
        end else begin
            feed_q       <= issue;
            feed_bias_q  <= issue && last_step;
            feed_first_q <= issue && first_step;
        end
    end

    // Outside a feed cycle all drive is zero, so the neuron holds its value.
    always_ff @(posedge clk) begin
        if (rst || !feed_q) begin
            n_input  <= '0;
            n_weight <= '0;
            n_zero   <= 1'b0;
            n_isbias <= 1'b0;
        end else begin
            n_input  <= feed_bias_q ? VW'(BIAS_ONE) : in_chunk;
            n_weight <= w_chunk;
            n_zero   <= feed_first_q;
            n_isbias <= feed_bias_q;
        end
    end

endmodule

// File: tb/tb_neural50_sequencer.sv
// Self-checking bench: sequencer driving a behavioural 50-lane neuron, checked
// against a per-neuron dot-product reference computed straight from the memories.
module tb_neural50_sequencer;
    import neural50_pkg::*;

    logic               clk = 1'b0;
    logic               rst, start;
    logic [CAW-1:0]     num_chunks;
    logic [NAW-1:0]     num_neurons;
    logic               busy, done, in_rd, w_rd;
    logic [CAW-1:0]     in_addr;
    logic [NAW+CAW-1:0] w_addr;
    logic [VW-1:0]      in_chunk = '0;
    logic [VW-1:0]      w_chunk  = '0;
    logic [VW-1:0]      n_input, n_weight;
    logic               n_zero, n_isbias;
    logic [DW-1:0]      n_last;
    logic [DW-1:0]      nrn_out = '0;
    logic               res_we;
    logic [NAW-1:0]     res_addr;
    logic [DW-1:0]      res_data;

    logic [VW-1:0] in_mem [MAX_CHUNKS];
    logic [VW-1:0] w_mem  [8][MAX_CHUNKS+1];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    neural50_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_chunks  (num_chunks),
        .num_neurons (num_neurons),
        .busy        (busy),
        .done        (done),
        .in_rd       (in_rd),
        .in_addr     (in_addr),
        .in_chunk    (in_chunk),
        .w_rd        (w_rd),
        .w_addr      (w_addr),
        .w_chunk     (w_chunk),
        .n_input     (n_input),
        .n_weight    (n_weight),
        .n_zero      (n_zero),
        .n_isbias    (n_isbias),
        .n_last      (n_last),
        .n_out       (nrn_out),
        .res_we      (res_we),
        .res_addr    (res_addr),
        .res_data    (res_data)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Synchronous read memories.
    always @(posedge clk) begin
        if (in_rd) in_chunk <= in_mem[int'(in_addr)];
        if (w_rd)  w_chunk  <= w_mem[int'(w_addr[CAW+2:CAW])][int'(w_addr[CAW-1:0])];
    end

    // Behavioural neuron: 50 products summed, sliced [11:4], accumulated mod 256.
    function automatic logic [7:0] mac_slice(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [31:0] sum = 0;
        for (int l = 0; l < LANES; l++) sum += 32'(a[8*l +: 8]) * 32'(b[8*l +: 8]);
        return sum[11:4];
    endfunction

    always @(posedge clk) nrn_out <= (n_zero ? 8'd0 : n_last) + mac_slice(n_input, n_weight);

    // Reference: result of neuron k over nc chunks plus its bias byte.
    function automatic logic [7:0] ref_result(input int k, input int nc);
        int acc = 0;
        for (int c = 0; c < nc; c++) begin
            int unsigned dot = 0;
            for (int l = 0; l < LANES; l++)
                dot += int'(in_mem[c][8*l +: 8]) * int'(w_mem[k][c][8*l +: 8]);
            acc = (acc + (dot / 16) % 256) % 256;
        end
        acc = (acc + int'(w_mem[k][MAX_CHUNKS][7:0])) % 256;
        return 8'(acc);
    endfunction

    // Monitor
    logic       mon_en = 1'b0;
    logic [7:0] exp_data [8];
    logic [7:0] got_data [8];
    int         wr_cnt, zero_cnt, bias_cnt, both_cnt, done_cnt;

    always @(negedge clk) begin
        if (mon_en) begin
            if (res_we) begin
                if (wr_cnt < 8) begin
                    check_eq("res_addr", res_addr, wr_cnt);
                    check_eq("res_data", res_data, exp_data[wr_cnt]);
                    got_data[wr_cnt] = res_data;
                end
                wr_cnt++;
            end
            zero_cnt += int'(n_zero);
            bias_cnt += int'(n_isbias);
            both_cnt += int'(n_zero && n_isbias);
            done_cnt += int'(done);
        end
    end

    task automatic clear_mon();
        wr_cnt = 0; zero_cnt = 0; bias_cnt = 0; both_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 8; i++) got_data[i] = 8'hxx;
    endtask

    task automatic fill_const(input int iv, input int wv, input int bias0);
        for (int c = 0; c < MAX_CHUNKS; c++)
            for (int l = 0; l < LANES; l++) in_mem[c][8*l +: 8] = 8'(iv);
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < MAX_CHUNKS; c++)
                for (int l = 0; l < LANES; l++) w_mem[k][c][8*l +: 8] = 8'(wv);
            // Junk in the non-bias lanes must be masked by the zero input lanes.
            for (int l = 1; l < LANES; l++) w_mem[k][MAX_CHUNKS][8*l +: 8] = 8'($urandom);
            w_mem[k][MAX_CHUNKS][7:0] = 8'(bias0 + k);
        end
    endtask

    task automatic fill_rand();
        for (int c = 0; c < MAX_CHUNKS; c++)
            for (int l = 0; l < LANES; l++) in_mem[c][8*l +: 8] = 8'($urandom);
        for (int k = 0; k < 8; k++)
            for (int c = 0; c <= MAX_CHUNKS; c++)
                for (int l = 0; l < LANES; l++) w_mem[k][c][8*l +: 8] = 8'($urandom);
    endtask

    task automatic pulse_start(input int nc, input int nn);
        @(negedge clk);
        start       = 1'b1;
        num_chunks  = CAW'(nc);
        num_neurons = NAW'(nn);
        @(posedge clk); #1;
        start       = 1'b0;
        num_chunks  = CAW'($urandom);
        num_neurons = NAW'($urandom);
    endtask

    task automatic run_layer(input int nc, input int nn, input bit mid_start, input bit done_start);
        int cyc;
        bit got_done;
        for (int k = 0; k < nn; k++) exp_data[k] = ref_result(k, nc);
        clear_mon();
        mon_en = 1'b1;
        pulse_start(nc, nn);
        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < nn * (nc + 4) + 20) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (cyc == 0) check_eq("busy_after_start", busy, 1);
                start = (mid_start && cyc == 2);
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        check_eq("done_seen", got_done, 1);
        check_eq("latency", cyc + 2, nn * (nc + 4) + 2);
        if (done_start) begin
            start = 1'b1; num_chunks = 0; num_neurons = 1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("done_one_cycle", done, 0);
        check_eq("idle_busy", busy, 0);
        @(posedge clk); #1;
        check_eq("no_restart", w_rd, 0);
        @(posedge clk); #1;
        mon_en = 1'b0;
        check_eq("write_count", wr_cnt, nn);
        check_eq("zero_count", zero_cnt, nn);
        check_eq("bias_count", bias_cnt, nn);
        check_eq("zero_and_bias", both_cnt, (nc == 0) ? nn : 0);
        check_eq("done_count", done_cnt, 1);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_in_rd"}, in_rd, 0);
        check_eq({tag, "_w_rd"}, w_rd, 0);
        check_eq({tag, "_res_we"}, res_we, 0);
        check_eq({tag, "_addrs"}, {in_addr, w_addr, res_addr, res_data}, 0);
        check_eq({tag, "_n_ctl"}, {n_zero, n_isbias}, 0);
        check_eq({tag, "_n_data_zero"}, (n_input == '0) && (n_weight == '0), 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_chunks = '0; num_neurons = '0;
        fill_const(1, 16, 5);
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;

        // Directed cases with all-ones inputs and weights of 16.
        run_layer(1, 1, 0, 1);
        check_eq("one_chunk_value", got_data[0], 55);
        run_layer(3, 1, 0, 0);
        check_eq("three_chunk_value", got_data[0], 155);
        run_layer(6, 1, 0, 0);
        check_eq("wrap_value", got_data[0], 49);
        fill_const(1, 16, 9);
        run_layer(0, 1, 0, 0);
        check_eq("bias_only_value", got_data[0], 9);
        fill_const(1, 16, 1);
        run_layer(1, 3, 1, 0);
        check_eq("multi_n0", got_data[0], 51);
        check_eq("multi_n1", got_data[1], 52);
        check_eq("multi_n2", got_data[2], 53);
        run_layer(2, 0, 0, 1);

        // Reset during neuron 1 of 3.
        fill_rand();
        for (int k = 0; k < 3; k++) exp_data[k] = ref_result(k, 2);
        clear_mon();
        mon_en = 1'b1;
        pulse_start(2, 3);
        repeat (2 + 4 + 1) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_quiet("midreset");
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check_eq("midreset_writes", wr_cnt, 1);
        check_eq("midreset_no_done", done_cnt, 0);
        run_layer(2, 3, 0, 0);

        // Randomized layers.
        for (int it = 0; it < 12; it++) begin
            int nc = $urandom_range(0, MAX_CHUNKS);
            int nn = $urandom_range(1, 8);
            fill_rand();
            run_layer(nc, nn, 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
